// File: rtl/updown_tracker_if.sv
// updown_tracker_if: groups the pulse inputs, control inputs and tracker
// outputs of updown_tracker into one bundle.
//   upPort/downPort : up/down pulse levels (clk-synchronous)
//   clear           : synchronous clear of position, flags and window state
//   window          : measurement window length in cycles (0 = rate off)
//   position        : signed accumulated net pulse count
//   rate            : signed net count of the last completed window
//   rate_valid      : one-cycle strobe when rate updates
//   sat_hi/sat_lo   : sticky saturation flags
// master drives the inputs (bench / upstream), slave is the tracker.
interface updown_tracker_if #(
  parameter int POS_W  = 24,
  parameter int RATE_W = 16,
  parameter int WIN_W  = 16
);
  logic                     upPort;
  logic                     downPort;
  logic                     clear;
  logic        [WIN_W-1:0]  window;
  logic signed [POS_W-1:0]  position;
  logic signed [RATE_W-1:0] rate;
  logic                     rate_valid;
  logic                     sat_hi;
  logic                     sat_lo;

  modport master (
    output upPort, downPort, clear, window,
    input  position, rate, rate_valid, sat_hi, sat_lo
  );

  modport slave (
    input  upPort, downPort, clear, window,
    output position, rate, rate_valid, sat_hi, sat_lo
  );
endinterface

// File: rtl/updown_tracker.sv
// updown_tracker: counts rising edges of up/down pulse levels into a
// saturating signed position, and measures the net count per window of
// programmable length.
//   clk   : sole clock, rising edge
//   reset : asynchronous active-high reset
//   bus   : updown_tracker_if.slave (inputs upPort, downPort, clear, window;
//           outputs position, rate, rate_valid, sat_hi, sat_lo -- all
//           outputs come straight from registers)
module updown_tracker #(
  parameter int POS_W  = 24,
  parameter int RATE_W = 16,
  parameter int WIN_W  = 16
) (
  input logic            clk,
  input logic            reset,
  updown_tracker_if.slave bus
);

  typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

  // Limits carried one bit wider so an overshooting sum is still comparable.
  localparam logic signed [POS_W:0]  POS_MAX  = {2'b00, {(POS_W-1){1'b1}}};
  localparam logic signed [POS_W:0]  POS_MIN  = {2'b11, {(POS_W-1){1'b0}}};
  localparam logic signed [RATE_W:0] RATE_MAX = {2'b00, {(RATE_W-1){1'b1}}};
  localparam logic signed [RATE_W:0] RATE_MIN = {2'b11, {(RATE_W-1){1'b0}}};
  localparam logic [WIN_W-1:0]       WIN_ONE  = {{(WIN_W-1){1'b0}}, 1'b1};
  localparam logic [WIN_W-1:0]       WIN_ZERO = {WIN_W{1'b0}};

  // Clamp a one-bit-wide rate sum into the RATE_W signed range.
  function automatic logic signed [RATE_W-1:0] sat_rate(input logic signed [RATE_W:0] v);
    logic signed [RATE_W-1:0] r;
    if (v > RATE_MAX) begin
      r = RATE_MAX[RATE_W-1:0];
    end else if (v < RATE_MIN) begin
      r = RATE_MIN[RATE_W-1:0];
    end else begin
      r = v[RATE_W-1:0];
    end
    return r;
  endfunction

  logic                     up_prev_r, down_prev_r;
  logic                     up_evt_s, down_evt_s;
  logic signed [1:0]        step_s;
  logic signed [POS_W-1:0]  position_r, pos_next_s;
  logic signed [POS_W:0]    pos_sum_s;
  logic                     sat_hi_r, sat_lo_r, hi_next_s, lo_next_s;
  logic signed [RATE_W-1:0] rate_r, rate_next_s, acc_r, acc_next_s, acc_sat_s;
  logic signed [RATE_W:0]   acc_sum_s;
  logic                     rate_valid_r, valid_next_s;
  state_t                   state_r, state_next_s;
  logic        [WIN_W-1:0]  win_q_r, win_next_s, cnt_r, cnt_next_s;
  logic                     boundary_s;

  // Edge detection and the signed step of this cycle.
  always_comb begin
    up_evt_s   = bus.upPort & ~up_prev_r;
    down_evt_s = bus.downPort & ~down_prev_r;
    step_s     = 2'sb00;
    case ({up_evt_s, down_evt_s})
      2'b10:   step_s = 2'sb01;
      2'b01:   step_s = 2'sb11;
      default: step_s = 2'sb00;
    endcase
  end

  // Saturating position update and sticky flag setting.
  always_comb begin
    pos_sum_s  = {position_r[POS_W-1], position_r} + {{(POS_W-1){step_s[1]}}, step_s};
    pos_next_s = position_r;
    hi_next_s  = sat_hi_r;
    lo_next_s  = sat_lo_r;
    if (bus.clear) begin
      pos_next_s = {POS_W{1'b0}};
      hi_next_s  = 1'b0;
      lo_next_s  = 1'b0;
    end else if ((step_s == 2'sb01) && (pos_sum_s >= POS_MAX)) begin
      // Landing on or overshooting the limit both pin it and flag it.
      pos_next_s = POS_MAX[POS_W-1:0];
      hi_next_s  = 1'b1;
    end else if ((step_s == 2'sb11) && (pos_sum_s <= POS_MIN)) begin
      pos_next_s = POS_MIN[POS_W-1:0];
      lo_next_s  = 1'b1;
    end else begin
      pos_next_s = pos_sum_s[POS_W-1:0];
    end
  end

  // Window FSM next-state and datapath; the boundary also folds in this cycle's step.
  always_comb begin
    acc_sum_s    = {acc_r[RATE_W-1], acc_r} + {{(RATE_W-1){step_s[1]}}, step_s};
    acc_sat_s    = sat_rate(acc_sum_s);
    boundary_s   = (state_r == RUN) && (cnt_r == (win_q_r - WIN_ONE));
    state_next_s = state_r;
    win_next_s   = win_q_r;
    cnt_next_s   = cnt_r;
    acc_next_s   = acc_r;
    rate_next_s  = rate_r;
    valid_next_s = 1'b0;
    if (bus.clear) begin
      state_next_s = IDLE;
      cnt_next_s   = WIN_ZERO;
      acc_next_s   = {RATE_W{1'b0}};
      rate_next_s  = {RATE_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          // The latch cycle's own step is intentionally not accumulated.
          if (bus.window != WIN_ZERO) begin
            state_next_s = RUN;
            win_next_s   = bus.window;
            cnt_next_s   = WIN_ZERO;
            acc_next_s   = {RATE_W{1'b0}};
          end else begin
            state_next_s = IDLE;
          end
        end
        RUN: begin
          if (boundary_s) begin
            rate_next_s  = acc_sat_s;
            valid_next_s = 1'b1;
            acc_next_s   = {RATE_W{1'b0}};
            cnt_next_s   = WIN_ZERO;
            if (bus.window == WIN_ZERO) begin
              state_next_s = IDLE;
            end else begin
              win_next_s = bus.window;
            end
          end else begin
            acc_next_s = acc_sat_s;
            cnt_next_s = cnt_r + WIN_ONE;
          end
        end
        default: begin
          state_next_s = IDLE;
        end
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Edge history, position, flags and window datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      up_prev_r    <= 1'b0;
      down_prev_r  <= 1'b0;
      position_r   <= {POS_W{1'b0}};
      sat_hi_r     <= 1'b0;
      sat_lo_r     <= 1'b0;
      rate_r       <= {RATE_W{1'b0}};
      rate_valid_r <= 1'b0;
      win_q_r      <= WIN_ZERO;
      cnt_r        <= WIN_ZERO;
      acc_r        <= {RATE_W{1'b0}};
    end else begin
      // Edge history keeps sampling even while clear is asserted.
      up_prev_r    <= bus.upPort;
      down_prev_r  <= bus.downPort;
      position_r   <= pos_next_s;
      sat_hi_r     <= hi_next_s;
      sat_lo_r     <= lo_next_s;
      rate_r       <= rate_next_s;
      rate_valid_r <= valid_next_s;
      win_q_r      <= win_next_s;
      cnt_r        <= cnt_next_s;
      acc_r        <= acc_next_s;
    end
  end

  assign bus.position   = position_r;
  assign bus.rate       = rate_r;
  assign bus.rate_valid = rate_valid_r;
  assign bus.sat_hi     = sat_hi_r;
  assign bus.sat_lo     = sat_lo_r;

endmodule

// File: tb/tb_updown_tracker.sv
// tb_updown_tracker: drives two tracker instances (wide default widths and a
// narrow POS_W=4 / RATE_W=3 one) with identical stimulus and compares every
// output each cycle against a behavioural model, plus directed sequences.
module tb_updown_tracker;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  updown_tracker_if #(.POS_W(24), .RATE_W(16), .WIN_W(16)) b0 ();
  updown_tracker_if #(.POS_W(4),  .RATE_W(3),  .WIN_W(16)) b1 ();

  updown_tracker #(.POS_W(24), .RATE_W(16), .WIN_W(16)) dut0 (.clk(clk), .reset(reset), .bus(b0));
  updown_tracker #(.POS_W(4),  .RATE_W(3),  .WIN_W(16)) dut1 (.clk(clk), .reset(reset), .bus(b1));

  int n_chk = 0;
  int n_fail = 0;

  // Behavioural model state
  int     pos_w [2] = '{24, 4};
  int     rate_w[2] = '{16, 3};
  bit     m_pu, m_pd;
  longint m_pos [2];
  bit     m_hi  [2];
  bit     m_lo  [2];
  longint m_rate[2];
  bit     m_valid;
  bit     m_run;
  int     m_len;
  int     m_q[$];   // steps seen so far in the current window

  typedef struct {
    bit up; bit dn; bit clr; int win; int exp_pos;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic longint lim_hi(input int w);
    return (longint'(1) << (w - 1)) - 1;
  endfunction

  function automatic longint lim_lo(input int w);
    return -(longint'(1) << (w - 1));
  endfunction

  // Net count of the window, saturating after every step.
  function automatic longint fold_rate(input int c);
    longint a = 0;
    foreach (m_q[i]) begin
      a = a + m_q[i];
      if (a > lim_hi(rate_w[c])) a = lim_hi(rate_w[c]);
      if (a < lim_lo(rate_w[c])) a = lim_lo(rate_w[c]);
    end
    return a;
  endfunction

  task automatic model_reset();
    m_pu = 1'b0; m_pd = 1'b0;
    for (int c = 0; c < 2; c++) begin
      m_pos[c] = 0; m_hi[c] = 1'b0; m_lo[c] = 1'b0; m_rate[c] = 0;
    end
    m_valid = 1'b0; m_run = 1'b0; m_len = 0; m_q.delete();
  endtask

  task automatic model_step(input bit up, input bit dn, input bit clr, input int win);
    bit ue, de;
    int st;
    longint nx;
    ue = up && !m_pu;
    de = dn && !m_pd;
    m_pu = up; m_pd = dn;
    st = int'(ue) - int'(de);
    m_valid = 1'b0;
    if (clr) begin
      for (int c = 0; c < 2; c++) begin
        m_pos[c] = 0; m_hi[c] = 1'b0; m_lo[c] = 1'b0; m_rate[c] = 0;
      end
      m_run = 1'b0; m_q.delete();
    end else begin
      for (int c = 0; c < 2; c++) begin
        nx = m_pos[c] + st;
        if (st > 0 && nx >= lim_hi(pos_w[c])) begin
          m_pos[c] = lim_hi(pos_w[c]); m_hi[c] = 1'b1;
        end else if (st < 0 && nx <= lim_lo(pos_w[c])) begin
          m_pos[c] = lim_lo(pos_w[c]); m_lo[c] = 1'b1;
        end else begin
          m_pos[c] = nx;
        end
      end
      if (!m_run) begin
        if (win != 0) begin
          m_run = 1'b1; m_len = win; m_q.delete();
        end
      end else begin
        m_q.push_back(st);
        if (m_q.size() == m_len) begin
          for (int c = 0; c < 2; c++) m_rate[c] = fold_rate(c);
          m_valid = 1'b1;
          m_q.delete();
          if (win == 0) m_run = 1'b0;
          else m_len = win;
        end
      end
    end
  endtask

  task automatic drive(input bit up, input bit dn, input bit clr, input int win);
    b0.upPort = up; b0.downPort = dn; b0.clear = clr; b0.window = 16'(win);
    b1.upPort = up; b1.downPort = dn; b1.clear = clr; b1.window = 16'(win);
  endtask

  task automatic compare_model();
    chk("d0.position",   longint'(b0.position),   m_pos[0]);
    chk("d0.rate",       longint'(b0.rate),       m_rate[0]);
    chk("d0.rate_valid", longint'(b0.rate_valid), longint'(m_valid));
    chk("d0.sat_hi",     longint'(b0.sat_hi),     longint'(m_hi[0]));
    chk("d0.sat_lo",     longint'(b0.sat_lo),     longint'(m_lo[0]));
    chk("d1.position",   longint'(b1.position),   m_pos[1]);
    chk("d1.rate",       longint'(b1.rate),       m_rate[1]);
    chk("d1.rate_valid", longint'(b1.rate_valid), longint'(m_valid));
    chk("d1.sat_hi",     longint'(b1.sat_hi),     longint'(m_hi[1]));
    chk("d1.sat_lo",     longint'(b1.sat_lo),     longint'(m_lo[1]));
  endtask

  // One clock: apply inputs, let the edge happen, check on the falling edge.
  task automatic cycle(input bit up, input bit dn, input bit clr, input int win);
    drive(up, dn, clr, win);
    @(posedge clk);
    model_step(up, dn, clr, win);
    @(negedge clk);
    compare_model();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".d0.position"},   longint'(b0.position),   0);
    chk({tag, ".d0.rate"},       longint'(b0.rate),       0);
    chk({tag, ".d0.rate_valid"}, longint'(b0.rate_valid), 0);
    chk({tag, ".d0.sat_hi"},     longint'(b0.sat_hi),     0);
    chk({tag, ".d0.sat_lo"},     longint'(b0.sat_lo),     0);
    chk({tag, ".d1.position"},   longint'(b1.position),   0);
    chk({tag, ".d1.sat_hi"},     longint'(b1.sat_hi),     0);
    chk({tag, ".d1.sat_lo"},     longint'(b1.sat_lo),     0);
  endtask

  // Assert reset between clock edges, check outputs at once, release off-edge.
  task automatic async_reset();
    #2 reset = 1'b1;
    #1 check_zero("async_reset");
    model_reset();
    @(posedge clk);
    @(negedge clk);
    #2 reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 0);
    #3 check_zero("por");
    #14 reset = 1'b0;
    model_reset();
    @(negedge clk);

    // Directed table: window off, 5 up pulses, 2 down pulses, simultaneous
    // rise, then up held for 10 cycles.
    for (int i = 0; i < 5; i++) begin
      tbl.push_back('{1'b1, 1'b0, 1'b0, 0, i + 1});
      tbl.push_back('{1'b0, 1'b0, 1'b0, 0, i + 1});
    end
    for (int i = 0; i < 2; i++) begin
      tbl.push_back('{1'b0, 1'b1, 1'b0, 0, 4 - i});
      tbl.push_back('{1'b0, 1'b0, 1'b0, 0, 4 - i});
    end
    tbl.push_back('{1'b1, 1'b1, 1'b0, 0, 3});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 0, 3});
    for (int i = 0; i < 10; i++) tbl.push_back('{1'b1, 1'b0, 1'b0, 0, 4});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 0, 4});
    foreach (tbl[i]) begin
      cycle(tbl[i].up, tbl[i].dn, tbl[i].clr, tbl[i].win);
      chk("tbl.position", longint'(b0.position), tbl[i].exp_pos);
      chk("tbl.rate_valid", longint'(b0.rate_valid), 0);
      chk("tbl.rate", longint'(b0.rate), 0);
    end

    // Narrow instance: saturation at +7 and -8, clear drops flag.
    async_reset();
    for (int p = 1; p <= 9; p++) begin
      cycle(1'b1, 1'b0, 1'b0, 0);
      chk("sat.position", longint'(b1.position), (p < 7) ? p : 7);
      chk("sat.sat_hi", longint'(b1.sat_hi), (p >= 7) ? 1 : 0);
      cycle(1'b0, 1'b0, 1'b0, 0);
    end
    cycle(1'b0, 1'b0, 1'b1, 0);
    chk("clr.position", longint'(b1.position), 0);
    chk("clr.sat_hi", longint'(b1.sat_hi), 0);
    for (int p = 1; p <= 9; p++) begin
      cycle(1'b0, 1'b1, 1'b0, 0);
      chk("satlo.position", longint'(b1.position), (p < 8) ? -p : -8);
      chk("satlo.sat_lo", longint'(b1.sat_lo), (p >= 8) ? 1 : 0);
      cycle(1'b0, 1'b0, 1'b0, 0);
    end

    // Window 8, up every other cycle; switched to 4 inside the third window.
    async_reset();
    cycle(1'b0, 1'b0, 1'b0, 8);
    for (int k = 0; k < 36; k++) begin
      bit expv;
      cycle((k % 2) == 0, 1'b0, 1'b0, (k < 18) ? 8 : 4);
      expv = (k == 7) || (k == 15) || (k == 23) || (k == 27) || (k == 31) || (k == 35);
      chk("win.rate_valid", longint'(b0.rate_valid), longint'(expv));
      if (expv) chk("win.rate", longint'(b0.rate), (k <= 23) ? 4 : 2);
    end

    // Window 1: strobe every cycle, rate follows each cycle's step.
    async_reset();
    cycle(1'b0, 1'b0, 1'b0, 1);
    for (int k = 0; k < 8; k++) begin
      bit u, d;
      u = (k == 1) || (k == 3);
      d = (k == 6);
      cycle(u, d, 1'b0, 1);
      chk("win1.rate_valid", longint'(b0.rate_valid), 1);
      chk("win1.rate", longint'(b0.rate), u ? 1 : (d ? -1 : 0));
    end

    // Reset in mid-window; up already high at release counts once.
    async_reset();
    cycle(1'b0, 1'b0, 1'b0, 8);
    for (int k = 0; k < 5; k++) cycle((k % 2) == 0, 1'b0, 1'b0, 8);
    drive(1'b1, 1'b0, 1'b0, 8);
    async_reset();
    cycle(1'b1, 1'b0, 1'b0, 8);
    chk("rel.position", longint'(b0.position), 1);
    for (int k = 0; k < 8; k++) begin
      cycle((k % 2) == 1, 1'b0, 1'b0, 8);
      chk("rel.rate_valid", longint'(b0.rate_valid), (k == 7) ? 1 : 0);
      if (k == 7) chk("rel.rate", longint'(b0.rate), 4);
    end

    // Randomized phase with drifting direction bias.
    begin
      int win_list[6] = '{0, 1, 2, 3, 5, 8};
      int win = 3;
      for (int i = 0; i < 3000; i++) begin
        int dir, up_p, dn_p;
        bit up, dn, clr;
        if ($urandom_range(0, 499) == 0) begin
          async_reset();
        end else begin
          dir  = (i / 128) % 3;
          up_p = (dir == 0) ? 70 : ((dir == 1) ? 15 : 50);
          dn_p = (dir == 1) ? 70 : ((dir == 0) ? 15 : 50);
          up   = $urandom_range(0, 99) < up_p;
          dn   = $urandom_range(0, 99) < dn_p;
          clr  = $urandom_range(0, 199) == 0;
          if ($urandom_range(0, 31) == 0) win = win_list[$urandom_range(0, 5)];
          cycle(up, dn, clr, win);
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/updown_tracker.md
UPDOWN_TRACKER -- requirements
Module: updown_tracker

Interface
REQ-001 Parameter POS_W, default 24, position accumulator width (two's complement).
REQ-002 Parameter RATE_W, default 16, windowed net-rate width (two's complement).
REQ-003 Parameter WIN_W, default 16, measurement-window length width.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 upPort  input  1  up-pulse level from the upstream up/down generator, synchronous to clk.
REQ-007 downPort  input  1  down-pulse level from the upstream up/down generator, synchronous to clk.
REQ-008 clear  input  1  synchronous clear of position, flags and window state.
REQ-009 window  input  WIN_W  measurement window length in clk cycles; 0 disables rate measurement.
REQ-010 position  output  POS_W  signed accumulated net pulse count.
REQ-011 rate  output  RATE_W  signed net pulse count of the last completed window.
REQ-012 rate_valid  output  1  single-cycle strobe when rate updates.
REQ-013 sat_hi  output  1  sticky flag: position has hit the positive limit.
REQ-014 sat_lo  output  1  sticky flag: position has hit the negative limit.

Function
REQ-015 Rising-edge detect per input: the event is in=1 at a clk edge while the registered previous sample is 0; each previous-sample register is cleared to 0 by reset.
REQ-016 Step: up event only -> +1; down event only -> -1; both or neither -> 0.
REQ-017 Latency: position reflects a step after the same clk edge that samples the input edge, so it is visible one cycle after the input rises.
REQ-018 A level held high counts once; the next count requires a low cycle first.
REQ-019 position saturates at 2^(POS_W-1)-1 and -2^(POS_W-1), with no wrap.
REQ-020 A step that would exceed a limit leaves position at that limit and sets the matching sticky flag (sat_hi or sat_lo).
REQ-021 A step that lands exactly on a limit also sets the matching sticky flag.
REQ-022 Sticky flags stay set until clear or reset.
REQ-023 On clear=1: position, sat_hi, sat_lo, rate and the window accumulator go to 0, rate_valid goes to 0, and the FSM goes to IDLE.
REQ-024 Edge detectors keep sampling during clear.
REQ-025 Steps arriving in a cycle with clear=1 are discarded.
REQ-026 Window FSM has two states, IDLE and RUN.
REQ-027 IDLE: rate holds its value and rate_valid is 0.
REQ-028 IDLE -> RUN when window != 0: latch window into win_q, set cycle counter to 0 and accumulator to 0.
REQ-029 RUN, each cycle: accumulator += step (saturating at RATE_W limits); cycle counter += 1.
REQ-030 RUN, in the cycle where counter == win_q-1: rate <= accumulator + that cycle's step (saturated), rate_valid = 1 for that cycle, accumulator and counter -> 0.
REQ-031 At a window boundary, if window == 0 the FSM goes to IDLE; otherwise win_q relatches window and the FSM stays in RUN.
REQ-032 Changing window mid-window has no effect until the next boundary.
REQ-033 With window == 1, rate_valid is asserted every cycle and rate equals that cycle's step.
REQ-034 The first cycle in RUN (the cycle after latching) is window cycle 0, and its step counts.
REQ-035 Steps occurring in the IDLE->RUN transition cycle are not counted toward rate.

Reset
REQ-036 While reset=1, asynchronously: position=0, rate=0, rate_valid=0, sat_hi=0, sat_lo=0, FSM=IDLE, counter=0, accumulator=0, edge registers=0.
REQ-037 Reset may be asserted at any time, including mid-window; the partial window is discarded with no rate_valid.
REQ-038 After reset deasserts, an input already high counts as one edge on the first clk edge.

Verification
REQ-039 Reset, window=0, 5 upPort pulses (1 high, 1 low each), then 2 downPort pulses -> position=3, rate_valid never asserted, rate=0.
REQ-040 upPort and downPort rise in the same cycle -> position unchanged; upPort held high for 10 cycles -> position +1 only.
REQ-041 POS_W=4, 9 up pulses -> position=7 after the 7th pulse and stays 7, sat_hi=1; clear -> position=0 and sat_hi=0 the next cycle.
REQ-042 window=8, one up pulse every 2 cycles -> rate_valid pulses every 8 cycles with rate=4; window switched to 4 mid-window -> the current window still completes at 8 cycles, and later windows give rate=2 every 4 cycles.
REQ-043 window=1 with an up pulse -> rate=+1 and rate_valid=1 on exactly that cycle; 0 on non-pulse cycles.
REQ-044 reset asserted asynchronously between clk edges in the middle of a window -> all outputs are 0 immediately, and no rate_valid follows after release until a full new window completes.
